instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter DEPTH, default 4, SHALL be the fetch-queue entry count (power of two, 2..8).
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  word-aligned fetch address; equals the current PC.
REQ-007 imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  in  1  read data valid, arriving at least 1 cycle after grant.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  branch/jump/ROB flush request.
REQ-011 redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
REQ-012 dec_ready  in  1  the decode stage accepts the queue head this cycle.
REQ-013 dec_valid  out  1  queue non-empty.
REQ-014 dec_instr  out  32  instruction at the queue head.
REQ-015 dec_pc  out  32  PC of the queue-head instruction.
REQ-016 queue_count  out  4  number of occupied queue entries.

Function
REQ-017 The block SHALL keep at most one memory request outstanding at any time.
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT, DROP.
REQ-019 IDLE -> REQ SHALL occur when queue_count < DEPTH and redirect_valid=0; otherwise the FSM SHALL stay in IDLE.
REQ-020 imem_req SHALL be 1 exactly while the FSM is in REQ, and imem_addr SHALL hold the PC stable until grant.
REQ-021 REQ -> WAIT SHALL occur on imem_gnt=1; at the same edge the PC SHALL increment by 4 (mod 2^32) and the request PC SHALL be latched as the tag.
REQ-022 WAIT -> IDLE SHALL occur on imem_rvalid=1, pushing {imem_rdata, tag} into the queue.
REQ-023 The queue SHALL be a circular FIFO; head/tail pointers SHALL wrap modulo DEPTH.
REQ-024 dec_valid SHALL equal (queue_count != 0); dec_instr and dec_pc SHALL come combinationally from the head entry.
REQ-025 A pop SHALL occur when dec_valid & dec_ready.
REQ-026 A push and a pop in the same cycle SHALL leave queue_count unchanged.
REQ-027 A push SHALL never target a full queue: a request is issued only when count < DEPTH, and only pops free entries.
REQ-028 On redirect_valid=1 the queue SHALL be emptied (count=0, head=tail=0) and PC SHALL be set to redirect_pc at that edge.
REQ-029 A redirect SHALL take priority over any simultaneous push and pop.
REQ-030 Redirect in IDLE or REQ SHALL go to IDLE; an ungranted request is withdrawn even if imem_gnt=1 in that cycle, and the PC is not incremented.
REQ-031 Redirect in WAIT with imem_rvalid=0 SHALL go to DROP.
REQ-032 Redirect in WAIT with imem_rvalid=1 SHALL go to IDLE, and that data SHALL be discarded.
REQ-033 DROP SHALL discard the response on imem_rvalid=1 and then go to IDLE.
REQ-034 A redirect in DROP SHALL update the PC only and remain in DROP.
REQ-035 With memory granting immediately and responding 1 cycle later, steady-state throughput SHALL be one instruction per 3 cycles, and fetch-to-dec_valid latency SHALL be 1 cycle after imem_rvalid.
REQ-036 imem_rvalid received in IDLE or REQ SHALL be ignored.

Reset
REQ-037 At a clock edge with reset_n=0: FSM=IDLE, PC=RESET_PC, queue_count=0, head=tail=0, tag=0.
REQ-038 While in reset, outputs SHALL be imem_req=0 and dec_valid=0.
REQ-039 Reset SHALL override redirect and all memory inputs; an in-flight response arriving after reset SHALL be ignored (FSM is in IDLE).
REQ-040 The first imem_req=1 with imem_addr=RESET_PC SHALL appear in the cycle after the first edge that samples reset_n=1.

Verification
REQ-041 Reset release, gnt always 1, rvalid 1 cycle after gnt, dec_ready=1 -> addresses 0,4,8,... requested in order; dec_pc follows 0,4,8 with the matching dec_instr.
REQ-042 dec_ready=0, DEPTH=4 -> after 4 responses queue_count=4, imem_req stays 0; one pop -> exactly one new request issued.
REQ-043 Redirect to 0x100 while in WAIT, rvalid two cycles later -> that response is discarded, queue_count=0, next imem_addr=0x100.
REQ-044 redirect_valid, imem_rvalid and dec_ready all 1 in one cycle with count=2 -> count=0 and nothing pushed; next fetch at redirect_pc.
REQ-045 Wrap check: 10 push/pop cycles with DEPTH=4 and random dec_ready -> FIFO order preserved across pointer wrap; PC 0xFFFF_FFFC + 4 -> 0x0000_0000.
REQ-046 reset_n=0 asserted while in WAIT, rvalid arrives after release -> the response is ignored and the first request is at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a single-outstanding-request memory fetcher feeding a
// circular instruction queue toward decode, with redirect (flush) support.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [3:0]  queue_count
);

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [3:0]      DEPTH_CNT = 4'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    fetch_state_t     state_r;
    fetch_state_t     next_state_s;
    logic [31:0]      pc_r;
    logic [31:0]      tag_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [3:0]       count_r;
    logic [3:0]       next_count_s;
    logic             req_r;
    logic             dvalid_r;
    logic             push_s;
    logic             pop_s;
    logic             grant_s;
    logic [31:0]      redirect_aligned_s;
    logic [31:0]      instr_q_r [DEPTH];
    logic [31:0]      pc_q_r    [DEPTH];

    // Low address bits of a redirect target are forced to zero.
    assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

    // A redirect suppresses every queue and PC side effect of the same cycle.
    assign grant_s = (state_r == ST_REQ) && imem_gnt && !redirect_valid;
    assign push_s  = (state_r == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign pop_s   = (count_r != 4'd0) && dec_ready && !redirect_valid;

    // Next-state logic of the fetch FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid) begin
                    next_state_s = ST_IDLE;
                end else if (count_r < DEPTH_CNT) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    next_state_s = ST_IDLE;
                end else if (imem_gnt) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    next_state_s = ST_IDLE;
                end else if (redirect_valid) begin
                    next_state_s = ST_DROP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                // The stale response retires the drop even if another redirect lands now.
                if (imem_rvalid) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DROP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Queue occupancy update.
    always_comb begin
        next_count_s = count_r;
        if (redirect_valid) begin
            next_count_s = 4'd0;
        end else if (push_s && !pop_s) begin
            next_count_s = count_r + 4'd1;
        end else if (pop_s && !push_s) begin
            next_count_s = count_r - 4'd1;
        end else begin
            next_count_s = count_r;
        end
    end

    // Control state: FSM, PC, tag, queue pointers and registered status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            tag_r    <= 32'h0000_0000;
            head_r   <= PTR_ZERO;
            tail_r   <= PTR_ZERO;
            count_r  <= 4'd0;
            req_r    <= 1'b0;
            dvalid_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            count_r  <= next_count_s;
            req_r    <= (next_state_s == ST_REQ);
            dvalid_r <= (next_count_s != 4'd0);
            if (redirect_valid) begin
                pc_r <= redirect_aligned_s;
            end else if (grant_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (grant_s) begin
                tag_r <= pc_r;
            end
            if (redirect_valid) begin
                head_r <= PTR_ZERO;
                tail_r <= PTR_ZERO;
            end else begin
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                if (push_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
            end
        end
    end

    // Queue storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clock) begin
        if (push_s) begin
            instr_q_r[tail_r] <= imem_rdata;
            pc_q_r[tail_r]    <= tag_r;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign dec_valid   = dvalid_r;
    assign dec_instr   = instr_q_r[head_r];
    assign dec_pc      = pc_q_r[head_r];
    assign queue_count = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (RESET_PC=0, DEPTH=4).
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [3:0]  queue_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .queue_count(queue_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Grant the pending request, then return data one cycle later.
    task automatic fetch_one(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; dec_ready = 1'b1;
        repeat (3) tick();
        total++;
        if ({imem_req, dec_valid, queue_count} !== 6'b000000) begin
            bad++; $display("FAIL reset_outputs: got %b want 000000", {imem_req, dec_valid, queue_count});
        end
        total++;
        if (imem_addr !== 32'h0000_0000) begin
            bad++; $display("FAIL reset_pc: got %h want 00000000", imem_addr);
        end
        reset_n = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0;
        tick();
        total++;
        if ({imem_req, imem_addr, queue_count} !== {1'b1, 32'h0000_0000, 4'd0}) begin
            bad++; $display("FAIL first_req: got req=%b addr=%h cnt=%0d want 1/00000000/0", imem_req, imem_addr, queue_count);
        end
        repeat (2) tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0000}) begin
            bad++; $display("FAIL req_hold: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_addr  = 32'(k * 4);
            exp_instr = 32'h1000_0013 + 32'(k);
            total++;
            if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
                bad++; $display("FAIL stream_addr%0d: got req=%b addr=%h want 1/%h", k, imem_req, imem_addr, exp_addr);
            end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            total++;
            if (imem_req !== 1'b0) begin
                bad++; $display("FAIL stream_wait%0d: got req=%b want 0", k, imem_req);
            end
            imem_rvalid = 1'b1; imem_rdata = exp_instr;
            tick();
            imem_rvalid = 1'b0;
            total++;
            if ({dec_valid, dec_pc, dec_instr} !== {1'b1, exp_addr, exp_instr}) begin
                bad++; $display("FAIL stream_dec%0d: got v=%b pc=%h ins=%h want 1/%h/%h", k, dec_valid, dec_pc, dec_instr, exp_addr, exp_instr);
            end
            tick();
        end
        dec_ready = 1'b0;
        total++;
        if ({dec_valid, queue_count, imem_req, imem_addr} !== {1'b0, 4'd0, 1'b1, 32'h0000_000C}) begin
            bad++; $display("FAIL stream_end: got v=%b cnt=%0d req=%b addr=%h want 0/0/1/0000000c", dec_valid, queue_count, imem_req, imem_addr);
        end
    endtask

    task automatic test_full();
        dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fetch_one(32'h2000_0000 + 32'(k));
            if (k < 3) tick();
        end
        total++;
        if ({queue_count, dec_valid, dec_pc, dec_instr} !== {4'd4, 1'b1, 32'h0000_000C, 32'h2000_0000}) begin
            bad++; $display("FAIL full_count: got cnt=%0d v=%b pc=%h ins=%h want 4/1/0000000c/20000000", queue_count, dec_valid, dec_pc, dec_instr);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (imem_req !== 1'b0) begin
                bad++; $display("FAIL full_noreq%0d: got req=%b want 0", k, imem_req);
            end
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        total++;
        if ({queue_count, imem_req, dec_pc, dec_instr} !== {4'd3, 1'b0, 32'h0000_0010, 32'h2000_0001}) begin
            bad++; $display("FAIL full_pop: got cnt=%0d req=%b pc=%h ins=%h want 3/0/00000010/20000001", queue_count, imem_req, dec_pc, dec_instr);
        end
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_001C}) begin
            bad++; $display("FAIL full_refill: got req=%b addr=%h want 1/0000001c", imem_req, imem_addr);
        end
        fetch_one(32'h2000_0004);
        repeat (2) tick();
        total++;
        if ({queue_count, imem_req} !== {4'd4, 1'b0}) begin
            bad++; $display("FAIL full_single: got cnt=%0d req=%b want 4/0", queue_count, imem_req);
        end
    endtask

    task automatic test_redirect_wait();
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0020}) begin
            bad++; $display("FAIL rw_req: got req=%b addr=%h want 1/00000020", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        total++;
        if ({queue_count, dec_valid, imem_req, imem_addr} !== {4'd0, 1'b0, 1'b0, 32'h0000_0100}) begin
            bad++; $display("FAIL rw_flush: got cnt=%0d v=%b req=%b addr=%h want 0/0/0/00000100", queue_count, dec_valid, imem_req, imem_addr);
        end
        tick();
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rw_drop: got req=%b want 0", imem_req);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
        tick();
        imem_rvalid = 1'b0;
        total++;
        if ({queue_count, dec_valid} !== {4'd0, 1'b0}) begin
            bad++; $display("FAIL rw_discard: got cnt=%0d v=%b want 0/0", queue_count, dec_valid);
        end
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100}) begin
            bad++; $display("FAIL rw_next: got req=%b addr=%h want 1/00000100", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_collide();
        fetch_one(32'h3000_0000);
        tick();
        fetch_one(32'h3000_0001);
        tick();
        total++;
        if ({queue_count, imem_req, imem_addr} !== {4'd2, 1'b1, 32'h0000_0108}) begin
            bad++; $display("FAIL rc_setup: got cnt=%0d req=%b addr=%h want 2/1/00000108", queue_count, imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h3000_0002; dec_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        imem_rvalid = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
        total++;
        if ({queue_count, dec_valid, imem_req, imem_addr} !== {4'd0, 1'b0, 1'b0, 32'h0000_0200}) begin
            bad++; $display("FAIL rc_flush: got cnt=%0d v=%b req=%b addr=%h want 0/0/0/00000200", queue_count, dec_valid, imem_req, imem_addr);
        end
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0200}) begin
            bad++; $display("FAIL rc_next: got req=%b addr=%h want 1/00000200", imem_req, imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; imem_gnt = 1'b1;
        tick();
        redirect_valid = 1'b0; imem_gnt = 1'b0;
        total++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0000_0300}) begin
            bad++; $display("FAIL rc_withdraw: got req=%b addr=%h want 0/00000300", imem_req, imem_addr);
        end
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0300}) begin
            bad++; $display("FAIL rc_reissue: got req=%b addr=%h want 1/00000300", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        logic [31:0] gnt_addr;
        logic [31:0] sb_pc [$];
        logic [31:0] sb_ins [$];
        logic [15:0] ready_pat;
        logic        granted;
        logic        saw_zero;
        int          pushes;
        int          pops;
        exp_pc = 32'hFFFF_FFFC; gnt_addr = 32'h0; ready_pat = 16'b1011_0010_1101_0110;
        granted = 1'b0; saw_zero = 1'b0; pushes = 0; pops = 0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_start: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
        end
        for (int i = 0; i < 60; i++) begin
            imem_rvalid = granted;
            imem_rdata  = gnt_addr ^ 32'h5A5A_5A5A;
            imem_gnt    = 1'b1;
            dec_ready   = ready_pat[4'(i)];
            if (dec_valid && dec_ready) begin
                total++;
                if (sb_pc.size() == 0) begin
                    bad++; $display("FAIL wrap_pop%0d: got pc=%h with empty model queue", i, dec_pc);
                end else begin
                    if ({dec_pc, dec_instr} !== {sb_pc[0], sb_ins[0]}) begin
                        bad++; $display("FAIL wrap_pop%0d: got pc=%h ins=%h want %h/%h", i, dec_pc, dec_instr, sb_pc[0], sb_ins[0]);
                    end
                    void'(sb_pc.pop_front());
                    void'(sb_ins.pop_front());
                end
                pops++;
            end
            if (granted) begin
                sb_pc.push_back(gnt_addr);
                sb_ins.push_back(gnt_addr ^ 32'h5A5A_5A5A);
                pushes++;
            end
            granted = imem_req;
            if (imem_req) begin
                total++;
                if (imem_addr !== exp_pc) begin
                    bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, imem_addr, exp_pc);
                end
                if (exp_pc == 32'h0000_0000) saw_zero = 1'b1;
                gnt_addr = exp_pc;
                exp_pc   = exp_pc + 32'd4;
            end
            tick();
            total++;
            if (queue_count !== 4'(sb_pc.size())) begin
                bad++; $display("FAIL wrap_count%0d: got %0d want %0d", i, queue_count, sb_pc.size());
            end
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0;
        total++;
        if (!saw_zero || pushes < 10 || pops < 10) begin
            bad++; $display("FAIL wrap_coverage: got zero=%b pushes=%0d pops=%0d want 1/>=10/>=10", saw_zero, pushes, pops);
        end
    endtask

    task automatic test_reset_wait();
        reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        total++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0000_0004}) begin
            bad++; $display("FAIL rst_wait_setup: got req=%b addr=%h want 0/00000004", imem_req, imem_addr);
        end
        reset_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({imem_req, dec_valid, queue_count, imem_addr} !== {1'b0, 1'b0, 4'd0, 32'h0000_0000}) begin
            bad++; $display("FAIL rst_wait_reset: got req=%b v=%b cnt=%0d addr=%h want 0/0/0/00000000", imem_req, dec_valid, queue_count, imem_addr);
        end
        reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
        tick();
        total++;
        if ({imem_req, imem_addr, queue_count} !== {1'b1, 32'h0000_0000, 4'd0}) begin
            bad++; $display("FAIL rst_wait_first: got req=%b addr=%h cnt=%0d want 1/00000000/0", imem_req, imem_addr, queue_count);
        end
        tick();
        imem_rvalid = 1'b0;
        total++;
        if ({imem_req, queue_count} !== {1'b1, 4'd0}) begin
            bad++; $display("FAIL rst_wait_ignore: got req=%b cnt=%0d want 1/0", imem_req, queue_count);
        end
        fetch_one(32'h0000_1234);
        total++;
        if ({dec_valid, dec_pc, dec_instr, queue_count} !== {1'b1, 32'h0000_0000, 32'h0000_1234, 4'd1}) begin
            bad++; $display("FAIL rst_wait_fetch: got v=%b pc=%h ins=%h cnt=%0d want 1/00000000/00001234/1", dec_valid, dec_pc, dec_instr, queue_count);
        end
    endtask

    initial begin
        reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_collide();
        test_wrap();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
